// File: rtl/mem_pkg.sv
// Shared types and defaults for the core memory responder: FSM state
// encoding, default geometry and the load-pointer width.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;

    // One extra bit so the load pointer can reach "depth" without wrapping.
    localparam int LOAD_PTR_W = DEF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,
        LOAD_HI = 2'd1,
        FINISH  = 2'd2,
        RUN     = 2'd3
    } mem_state_t;

    function automatic int load_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// Core-side memory port: word address, write data and strobe from the core,
// read data back. The core is the master, the responder is the slave.
interface core_mem_responder_if;
    import mem_pkg::*;

    logic [15:0]               to_mem_addr;
    logic [DEF_DATA_WIDTH-1:0] core_to_mem_data;
    logic                      core_to_mem_write_enable;
    logic [DEF_DATA_WIDTH-1:0] from_mem_data;

    modport master (
        output to_mem_addr,
        output core_to_mem_data,
        output core_to_mem_write_enable,
        input  from_mem_data
    );

    modport slave (
        input  to_mem_addr,
        input  core_to_mem_data,
        input  core_to_mem_write_enable,
        output from_mem_data
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered, write-first read port.
// The read register only advances when re is high, so it holds otherwise.
module mem_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rd_zero,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (rd_zero) begin
                rdata_d = '0;
            end else if (we) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem[addr];
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/core_mem_responder.sv
// Unified memory beside the pipelined core: loads a byte-serial program image
// after reset while holding the core, then serves 1-cycle reads / write-first writes.
module core_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    core_mem_responder_if.slave   bus,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    input  logic                  load_done,
    output logic                  core_hold,
    output logic                  addr_fault,
    output mem_state_t            dbg_state
);

    localparam int PTR_W = load_ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** ADDR_WIDTH);

    mem_state_t            state_q,    state_d;
    logic [PTR_W-1:0]      load_ptr_q, load_ptr_d;
    logic [7:0]            lo_q,       lo_d;
    logic                  fault_q,    fault_d;
    logic                  hold_q,     hold_d;

    logic                  in_load;
    logic                  run;
    logic                  ptr_room;
    logic                  accept;
    logic                  in_range;
    logic                  ld_we;
    logic [DATA_WIDTH-1:0] ld_word;

    logic                  arr_we;
    logic                  arr_re;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign in_load  = (state_q == LOAD_LO) || (state_q == LOAD_HI);
    assign run      = (state_q == RUN);
    assign ptr_room = (load_ptr_q < DEPTH);
    assign in_range = ((bus.to_mem_addr >> ADDR_WIDTH) == 16'd0);

    // Load handshake: a byte transfers on any rising edge where load_valid and
    // load_ready are both high; load_ready never depends on load_valid, and a
    // byte offered with load_ready low is simply not taken.
    assign load_ready = !reset && in_load && ptr_room;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        lo_d       = lo_q;
        fault_d    = fault_q;
        ld_we      = 1'b0;
        ld_word    = '0;

        case (state_q)
            LOAD_LO: begin
                if (accept && load_done) begin
                    // Odd final byte: commit it zero-extended right away.
                    ld_we      = 1'b1;
                    ld_word    = {8'h00, load_byte};
                    load_ptr_d = load_ptr_q + PTR_W'(1);
                    state_d    = FINISH;
                end else if (accept) begin
                    lo_d    = load_byte;
                    state_d = LOAD_HI;
                end else if (load_done) begin
                    state_d = FINISH;
                end
            end
            LOAD_HI: begin
                if (accept || load_done) begin
                    ld_we      = 1'b1;
                    ld_word    = accept ? {load_byte, lo_q} : {8'h00, lo_q};
                    load_ptr_d = load_ptr_q + PTR_W'(1);
                    state_d    = load_done ? FINISH : LOAD_LO;
                end
            end
            FINISH: begin
                state_d = RUN;
            end
            RUN: begin
                if (!in_range) begin
                    fault_d = 1'b1;
                end
            end
            default: begin
                state_d = LOAD_LO;
            end
        endcase

        if (in_load && load_valid && !ptr_room) begin
            fault_d = 1'b1;
        end

        hold_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_LO;
            load_ptr_q <= '0;
            lo_q       <= '0;
            fault_q    <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            lo_q       <= lo_d;
            fault_q    <= fault_d;
            hold_q     <= hold_d;
        end
    end

    // The single RAM port belongs to the loader until RUN, then to the core.
    assign arr_addr  = run ? bus.to_mem_addr[ADDR_WIDTH-1:0] : load_ptr_q[ADDR_WIDTH-1:0];
    assign arr_wdata = run ? bus.core_to_mem_data : ld_word;
    assign arr_we    = !reset && (run ? (bus.core_to_mem_write_enable && in_range) : ld_we);
    assign arr_re    = run;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .rst     (reset),
        .we      (arr_we),
        .re      (arr_re),
        .rd_zero (!in_range),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
        .rdata   (arr_rdata)
    );

    assign bus.from_mem_data = arr_rdata;
    assign core_hold         = hold_q;
    assign addr_fault        = fault_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: a 1K-word instance for load/run
// behaviour and a 4-word instance for load overflow.
module tb_core_mem_responder;
    import mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: default geometry (ADDR_WIDTH = 10)
    logic       a_reset, a_load_valid, a_load_done;
    logic [7:0] a_load_byte;
    logic       a_load_ready, a_core_hold, a_fault;
    mem_state_t a_state;
    core_mem_responder_if a_bus ();

    core_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .bus        (a_bus),
        .load_valid (a_load_valid),
        .load_byte  (a_load_byte),
        .load_ready (a_load_ready),
        .load_done  (a_load_done),
        .core_hold  (a_core_hold),
        .addr_fault (a_fault),
        .dbg_state  (a_state)
    );

    // Instance B: 4-word memory for the overflow case
    logic       b_reset, b_load_valid, b_load_done;
    logic [7:0] b_load_byte;
    logic       b_load_ready, b_core_hold, b_fault;
    mem_state_t b_state;
    core_mem_responder_if b_bus ();

    core_mem_responder #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .bus        (b_bus),
        .load_valid (b_load_valid),
        .load_byte  (b_load_byte),
        .load_ready (b_load_ready),
        .load_done  (b_load_done),
        .core_hold  (b_core_hold),
        .addr_fault (b_fault),
        .dbg_state  (b_state)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (instance A) ----------------
    task automatic a_reset_pulse(input int cycles);
        @(negedge clk);
        a_reset = 1'b1;
        a_load_valid = 1'b0;
        a_load_done  = 1'b0;
        a_bus.core_to_mem_write_enable = 1'b0;
        a_bus.to_mem_addr = 16'h0000;
        repeat (cycles) @(negedge clk);
        check("rst_core_hold", 32'(a_core_hold), 32'd1);
        check("rst_load_ready", 32'(a_load_ready), 32'd0);
        check("rst_from_mem_data", 32'(a_bus.from_mem_data), 32'h0);
        check("rst_addr_fault", 32'(a_fault), 32'd0);
        check("rst_state", 32'(a_state), 32'(LOAD_LO));
        a_reset = 1'b0;
    endtask

    // Streams an image; load_done rides on the last byte or follows it.
    task automatic a_load(input logic [7:0] img[$], input bit done_on_last);
        foreach (img[i]) begin
            @(negedge clk);
            check("load_ready", 32'(a_load_ready), 32'd1);
            a_load_valid = 1'b1;
            a_load_byte  = img[i];
            a_load_done  = done_on_last && (i == img.size() - 1);
        end
        if (!done_on_last) begin
            @(negedge clk);
            a_load_valid = 1'b0;
            a_load_done  = 1'b1;
        end
        @(negedge clk);
        a_load_valid = 1'b0;
        a_load_done  = 1'b0;
        check("hold_in_finish", 32'(a_core_hold), 32'd1);
        check("state_finish", 32'(a_state), 32'(FINISH));
        check("from_mem_held", 32'(a_bus.from_mem_data), 32'h0);
        @(negedge clk);
        check("hold_falls", 32'(a_core_hold), 32'd0);
        check("state_run", 32'(a_state), 32'(RUN));
    endtask

    task automatic a_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
        @(negedge clk);
        a_bus.to_mem_addr = addr;
        a_bus.core_to_mem_write_enable = 1'b0;
        @(negedge clk);
        check(name, 32'(a_bus.from_mem_data), 32'(exp));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    localparam int N_VEC = 14;
    vec_t vecs[N_VEC];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] img[$];

        a_reset = 1'b1; a_load_valid = 1'b0; a_load_done = 1'b0; a_load_byte = 8'h00;
        a_bus.to_mem_addr = 16'h0000;
        a_bus.core_to_mem_data = 16'h0000;
        a_bus.core_to_mem_write_enable = 1'b0;
        b_reset = 1'b1; b_load_valid = 1'b0; b_load_done = 1'b0; b_load_byte = 8'h00;
        b_bus.to_mem_addr = 16'h0000;
        b_bus.core_to_mem_data = 16'h0000;
        b_bus.core_to_mem_write_enable = 1'b0;

        vecs[0]  = '{16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0};
        vecs[1]  = '{16'h0001, 1'b0, 16'h0000, 16'h5678, 1'b0};
        vecs[2]  = '{16'h0005, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[3]  = '{16'h0005, 1'b0, 16'h0000, 16'hBEEF, 1'b0};
        vecs[4]  = '{16'h0002, 1'b1, 16'h0102, 16'h0102, 1'b0};
        vecs[5]  = '{16'h03FF, 1'b1, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[6]  = '{16'h03FF, 1'b0, 16'h0000, 16'hA5A5, 1'b0};
        vecs[7]  = '{16'h0002, 1'b0, 16'h0000, 16'h0102, 1'b0};
        vecs[8]  = '{16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0};
        vecs[9]  = '{16'h0400, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[10] = '{16'h0400, 1'b1, 16'h9999, 16'h0000, 1'b1};
        vecs[11] = '{16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b1};
        vecs[12] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[13] = '{16'h0005, 1'b0, 16'h0000, 16'hBEEF, 1'b1};

        // Even image; the core tries to write mem[0] while held off.
        a_reset_pulse(2);
        a_bus.to_mem_addr = 16'h0000;
        a_bus.core_to_mem_data = 16'hDEAD;
        a_bus.core_to_mem_write_enable = 1'b1;
        img = '{8'h34, 8'h12, 8'h78, 8'h56};
        a_load(img, 1'b0);
        a_bus.core_to_mem_write_enable = 1'b0;
        check("fault_after_load", 32'(a_fault), 32'd0);
        a_read(16'h0001, 16'h5678, "first_read_addr1");

        foreach (vecs[i]) begin
            @(negedge clk);
            a_bus.to_mem_addr = vecs[i].addr;
            a_bus.core_to_mem_write_enable = vecs[i].we;
            a_bus.core_to_mem_data = vecs[i].wdata;
            @(negedge clk);
            a_bus.core_to_mem_write_enable = 1'b0;
            check($sformatf("vec%0d_rd", i), 32'(a_bus.from_mem_data), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_fault", i), 32'(a_fault), 32'(vecs[i].exp_fault));
        end
        a_bus.to_mem_addr = 16'h0000;

        // Odd image with load_done on the last byte; reset also clears the fault.
        a_reset_pulse(1);
        img = '{8'hAA, 8'hBB, 8'hCC};
        a_load(img, 1'b1);
        a_read(16'h0000, 16'hBBAA, "odd_mem0");
        a_read(16'h0001, 16'h00CC, "odd_mem1");

        // Reset with a pending low byte, then reload.
        a_reset_pulse(1);
        @(negedge clk);
        a_load_valid = 1'b1;
        a_load_byte  = 8'h77;
        @(negedge clk);
        a_load_valid = 1'b0;
        check("stale_lo_state", 32'(a_state), 32'(LOAD_HI));
        a_reset_pulse(1);
        img = '{8'h11, 8'h22};
        a_load(img, 1'b0);
        a_read(16'h0000, 16'h2211, "reload_mem0");
        a_read(16'h0001, 16'h00CC, "retained_mem1");
        a_read(16'h0005, 16'hBEEF, "retained_mem5");

        // Overflow on the 4-word instance: 10 bytes offered back to back.
        @(negedge clk);
        check("b_rst_ready", 32'(b_load_ready), 32'd0);
        check("b_rst_hold", 32'(b_core_hold), 32'd1);
        b_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                check($sformatf("b_ready_byte%0d", i), 32'(b_load_ready), 32'd1);
            end else if (i == 8) begin
                check("b_ready_full", 32'(b_load_ready), 32'd0);
                check("b_fault_before_extra", 32'(b_fault), 32'd0);
            end
            b_load_valid = 1'b1;
            b_load_byte  = 8'(i + 1);
        end
        @(negedge clk);
        b_load_valid = 1'b0;
        b_load_done  = 1'b1;
        check("b_fault_overflow", 32'(b_fault), 32'd1);
        @(negedge clk);
        b_load_done = 1'b0;
        @(negedge clk);
        check("b_hold_falls", 32'(b_core_hold), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_bus.to_mem_addr = 16'(i);
            @(negedge clk);
            check($sformatf("b_mem%0d", i), 32'(b_bus.from_mem_data),
                  32'({8'(2 * i + 2), 8'(2 * i + 1)}));
        end
        check("b_fault_sticky", 32'(b_fault), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
